ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001: Parameter DEPTH, default 4, queue entries and maximum in-flight fetches; power of two, 2..16.
REQ-002: Parameter RESET_PC, default 32'd0, first fetch address after reset.
REQ-003: clk_i  input  1  single clock; all state on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-high reset (asserted = 1); clears all state immediately.
REQ-005: imem_req_o  output  1  fetch request valid.
REQ-006: imem_addr_o  output  32  fetch address; equals fetch_pc.
REQ-007: imem_gnt_i  input  1  memory accepts request this cycle when imem_req_o=1.
REQ-008: imem_rvalid_i  input  1  read data valid; responses return in request order, latency >=1 cycle.
REQ-009: imem_rdata_i  input  32  instruction word.
REQ-010: redirect_i  input  1  taken branch or jump from EX/MEM; flush and refetch.
REQ-011: redirect_pc_i  input  32  new fetch address.
REQ-012: instr_valid_o  output  1  queue head valid toward the IF/ID register.
REQ-013: instr_ready_i  input  1  IF/ID accepts the head; low during hazard stall.
REQ-014: instr_o  output  32  head instruction.
REQ-015: pc_plus4_o  output  32  head instruction address + 4.

Function
REQ-016: Internal state: fetch_pc, resp_pc, FIFO (DEPTH x 64: instr, pc+4), count (0..DEPTH), outstanding (0..DEPTH), discard_cnt (0..DEPTH).
REQ-017: imem_req_o = !redirect_i && (outstanding + count < DEPTH); combinational, no dependence on imem_gnt_i.
REQ-018: Grant (imem_req_o && imem_gnt_i): fetch_pc <= fetch_pc + 4 (mod 2^32); outstanding increments.
REQ-019: Response (imem_rvalid_i, outstanding>0): outstanding decrements; if discard_cnt>0, drop the data and decrement discard_cnt; otherwise push {imem_rdata_i, resp_pc+4} and resp_pc <= resp_pc + 4.
REQ-020: imem_rvalid_i with outstanding=0 is ignored, with no state change.
REQ-021: instr_valid_o = (count>0) && !redirect_i; instr_o/pc_plus4_o = head entry; pop when instr_valid_o && instr_ready_i.
REQ-022: Push and pop in the same cycle leave count unchanged; the credit rule in REQ-017 guarantees no push when full.
REQ-023: Latency: data pushed at edge N is presented on instr_o after edge N, with no bypass. Minimum request-to-output latency = memory latency + 1 cycle.
REQ-024: Redirect cycle: no push, no pop. At the edge: count<=0, pointers cleared, fetch_pc<=redirect_pc_i, resp_pc<=redirect_pc_i, discard_cnt<=outstanding_next, where outstanding_next = outstanding - (imem_rvalid_i && outstanding>0 ? 1 : 0). Any response arriving in that cycle is dropped.
REQ-025: A redirect while discard_cnt>0 is handled by the same rule. Stale responses still in flight are all counted and discarded.
REQ-026: Requests to the new address may issue from the cycle after the redirect, while discard continues. In-order return guarantees that the first discard_cnt responses are stale.
REQ-027: Back-to-back redirects: the last redirect_pc_i wins.
REQ-028: Counters never wrap: outstanding and count are each <= DEPTH, and their sum is <= DEPTH.

Reset
REQ-029: While rst_n=1: imem_req_o=0, instr_valid_o=0, instr_o=0, pc_plus4_o=0. fetch_pc=resp_pc=RESET_PC. count=outstanding=discard_cnt=0. FIFO contents are don't-care but never presented.
REQ-030: Mid-operation reset drops all in-flight responses. The memory side is reset by the same signal.
REQ-031: First imem_req_o=1 occurs in the first cycle after rst_n deasserts, with imem_addr_o=RESET_PC.

Verification
REQ-032: Streaming: gnt=1 always, latency 1, ready=1 -> instr_o sequence at addresses 0,4,8,12..., pc_plus4_o = 4,8,12,16..., one instruction per cycle after 2-cycle fill.
REQ-033: Backpressure: ready=0 for 10 cycles, DEPTH=4 -> exactly 4 grants, then imem_req_o=0. count=4, no overflow. On release, 4 entries drain in order and fetching resumes at address 16.
REQ-034: Redirect with 3 outstanding (latency 3): redirect_pc_i=0x100 -> the next 3 responses are dropped, and the first instr_valid_o carries pc_plus4_o=0x104.
REQ-035: Redirect coincident with rvalid and pop (count=2): the response is dropped, discard_cnt=outstanding-1, no pop is counted, and instr_valid_o=0 that cycle.
REQ-036: Reset asserted mid-stream (outstanding=2, count=3): outputs zero immediately (asynchronously). After release, a fetch at RESET_PC occurs and no stale data ever appears on instr_o.
REQ-037: Spurious rvalid with outstanding=0 -> no push, count unchanged.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: instruction memory request/response, branch redirect and
// the decoupling queue's output toward IF/ID. The fetch unit is the slave.
interface ifetch_queue_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;

    modport slave (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output pc_plus4_o
    );

    modport master (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  pc_plus4_o
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a credit-limited decoupling queue. Stale responses
// left in flight by a redirect are counted and dropped as they return in order.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic          clk_i,
    input  logic          rst_n,
    ifetch_queue_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_discard;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [63:0]   r_mem [DEPTH];

    logic [CW:0]   w_inflight;
    logic          w_req;
    logic          w_grant;
    logic          w_resp;
    logic          w_push;
    logic          w_have;
    logic          w_valid;
    logic          w_pop;
    logic [CW-1:0] w_outst_next;
    logic [63:0]   w_head;

    // Credits cover both queued entries and in-flight fetches, so a response
    // always has a free slot when it lands.
    assign w_inflight = {1'b0, r_outst} + {1'b0, r_count};
    assign w_req      = !rst_n && !bus.redirect_i && (w_inflight < DEPTH_W);
    assign w_grant    = w_req && bus.imem_gnt_i;
    assign w_resp     = bus.imem_rvalid_i && (r_outst != '0);
    assign w_push     = w_resp && (r_discard == '0) && !bus.redirect_i;
    assign w_have     = (r_count != '0);
    assign w_valid    = w_have && !bus.redirect_i;
    assign w_pop      = w_valid && bus.instr_ready_i;

    assign w_outst_next = r_outst + CW'(w_grant) - CW'(w_resp);
    assign w_head       = r_mem[r_rd_ptr];

    assign bus.imem_req_o    = w_req;
    assign bus.imem_addr_o   = r_fetch_pc;
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = w_have ? w_head[63:32] : 32'd0;
    assign bus.pc_plus4_o    = w_have ? w_head[31:0]  : 32'd0;

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_count    <= '0;
            r_outst    <= '0;
            r_discard  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_outst <= w_outst_next;
            if (bus.redirect_i) begin
                r_fetch_pc <= bus.redirect_pc_i;
                r_resp_pc  <= bus.redirect_pc_i;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                // Everything still outstanding after this edge belongs to the old path.
                r_discard  <= r_outst - CW'(w_resp);
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_resp && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: an entry is only presented while r_count covers it.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.imem_rdata_i, r_resp_pc + 32'd4};
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Random-stimulus bench for ifetch_queue: in-order memory model with tagged
// requests and an expected-instruction queue as the reference.
module tb_ifetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'd0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_queue_if bus();

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk_i (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [63:0] q[$];
    logic [31:0] m_pc;
    int          epoch = 0;
    int          cyc   = 0;
    int          errors = 0;
    int          checks = 0;
    int          grants_seen = 0;

    int p_gnt, p_rdy, p_redir, p_rv, p_spur, lat_lo, lat_hi;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc    = 32'd0;

    function automatic logic [31:0] mdata(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.imem_gnt_i    = ($urandom_range(99) < p_gnt);
        bus.instr_ready_i = ($urandom_range(99) < p_rdy);
        if (force_redir) begin
            bus.redirect_i    = 1'b1;
            bus.redirect_pc_i = force_pc;
        end else begin
            bus.redirect_i    = ($urandom_range(99) < p_redir);
            bus.redirect_pc_i = 32'h0000_1000 + 32'($urandom_range(63) << 2);
        end
        if (pend.size() > 0) begin
            bus.imem_rvalid_i = (pend[0].due <= cyc) && ($urandom_range(99) < p_rv);
            bus.imem_rdata_i  = mdata(pend[0].addr);
        end else begin
            bus.imem_rvalid_i = ($urandom_range(99) < p_spur);
            bus.imem_rdata_i  = $urandom;
        end
    endtask

    // One clock: drive, check combinational outputs, advance the model, clock.
    task automatic step();
        bit   m_req, m_valid, redir, grant, resp, pop;
        req_t e;
        drive();
        #2;
        redir   = bus.redirect_i;
        m_req   = !redir && ((pend.size() + q.size()) < DEPTH);
        m_valid = (q.size() > 0) && !redir;
        chk("req", {31'd0, bus.imem_req_o}, {31'd0, m_req});
        chk("addr", bus.imem_addr_o, m_pc);
        chk("valid", {31'd0, bus.instr_valid_o}, {31'd0, m_valid});
        if (m_valid) begin
            chk("instr", bus.instr_o, q[0][63:32]);
            chk("pc_plus4", bus.pc_plus4_o, q[0][31:0]);
        end
        if (bus.imem_req_o && bus.imem_gnt_i) grants_seen++;

        grant = m_req && bus.imem_gnt_i;
        resp  = bus.imem_rvalid_i && (pend.size() > 0);
        pop   = m_valid && bus.instr_ready_i;
        if (pop) void'(q.pop_front());
        if (resp) begin
            e = pend.pop_front();
            if (!redir && e.epoch == epoch)
                q.push_back({mdata(e.addr), e.addr + 32'd4});
        end
        if (grant) begin
            e.addr  = m_pc;
            e.epoch = epoch;
            e.due   = cyc + $urandom_range(lat_hi, lat_lo);
            pend.push_back(e);
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            epoch++;
            q.delete();
            m_pc = bus.redirect_pc_i;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_knobs(int g, int r, int rd, int rv, int sp, int lo, int hi);
        p_gnt = g; p_rdy = r; p_redir = rd; p_rv = rv; p_spur = sp; lat_lo = lo; lat_hi = hi;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_req"},   {31'd0, bus.imem_req_o},    32'd0);
        chk({tag, "_valid"}, {31'd0, bus.instr_valid_o}, 32'd0);
        chk({tag, "_instr"}, bus.instr_o,                32'd0);
        chk({tag, "_pc4"},   bus.pc_plus4_o,             32'd0);
    endtask

    task automatic model_reset();
        pend.delete();
        q.delete();
        epoch++;
        m_pc = RPC;
    endtask

    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'd0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'd0;
        bus.instr_ready_i = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("por");
        chk("por_addr", bus.imem_addr_o, RPC);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Backpressure from empty: exactly DEPTH grants, then no requests.
        set_knobs(100, 0, 0, 100, 0, 1, 1);
        grants_seen = 0;
        for (int i = 0; i < 10; i++) step();
        chk("bp_grants", 32'(grants_seen), 32'(DEPTH));

        // Release: drain in order, fetching resumes at 16, then steady streaming.
        set_knobs(100, 100, 0, 100, 0, 1, 1);
        for (int i = 0; i < 30; i++) step();

        // Latency 3 with a forced redirect to 0x100 mid-stream.
        set_knobs(100, 100, 0, 100, 0, 3, 3);
        for (int i = 0; i < 8; i++) step();
        force_redir = 1'b1;
        force_pc    = 32'h0000_0100;
        step();
        force_redir = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Mixed random traffic with redirects, stalls and spurious responses.
        set_knobs(70, 70, 8, 80, 25, 1, 4);
        for (int i = 0; i < 500; i++) step();

        // Asynchronous reset in the middle of a cycle.
        set_knobs(100, 30, 0, 100, 0, 2, 3);
        for (int i = 0; i < 6; i++) step();
        drive();
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;

        set_knobs(60, 60, 10, 70, 20, 1, 5);
        for (int i = 0; i < 500; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
